// File: rtl/btn_debounce_pkg.sv
// Shared state encoding for the button debouncer.
// The encoding values are fixed so that waveforms and other blocks read the same numbers.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

endpackage

// File: rtl/btn_debounce_sync_2ff.sv
// Reusable two-flop synchroniser bringing an asynchronous bit into the clk domain.
// Only q may be used downstream; the first stage can be metastable.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_s1;
  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_q  <= 1'b0;
    end else begin
      r_s1 <= d;
      r_q  <= r_s1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/btn_debounce.sv
// Button debouncer: synchronises btn_in, accepts a new level only after it has been stable
// for STABLE_CYCLES clocks, and produces a clean level plus one-cycle rise/fall pulses.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_WIDTH     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic busy
);

  localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                 w_btn_s;
  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_level;
  logic                 r_rise;
  logic                 r_fall;
  logic                 r_busy;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (w_btn_s)
  );

  // Outputs are assigned on the transitions themselves so they stay registered and
  // line up with the state they describe; the counter saturates at LP_CNT_LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        S_LOW: begin
          if (w_btn_s) begin
            r_state <= S_WAIT_HI;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_WAIT_HI: begin
          if (!w_btn_s) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_state <= S_HIGH;
            r_level <= 1'b1;
            r_rise  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
        S_HIGH: begin
          if (!w_btn_s) begin
            r_state <= S_WAIT_LO;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_WAIT_LO: begin
          if (w_btn_s) begin
            r_state <= S_HIGH;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_state <= S_LOW;
            r_level <= 1'b0;
            r_fall  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          r_state <= S_LOW;
          r_cnt   <= '0;
          r_level <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level = r_level;
  assign btn_rise  = r_rise;
  assign btn_fall  = r_fall;
  assign busy      = r_busy;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with STABLE_CYCLES=4, plus a STABLE_CYCLES=1 instance
// sharing the same inputs to cover the single-sample acceptance case.
module tb_btn_debounce;

  logic clock = 1'b0;
  logic reset;
  logic btnIn;
  logic level4, rise4, fall4, busy4;
  logic level1, rise1, fall1, busy1;
  int   checks = 0;
  int   errors = 0;
  logic bouncePattern [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic bounceBusy    [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  btn_debounce #(.STABLE_CYCLES(4), .CNT_WIDTH(3)) dut4 (
    .clk       (clock),
    .rst       (reset),
    .btn_in    (btnIn),
    .btn_level (level4),
    .btn_rise  (rise4),
    .btn_fall  (fall4),
    .busy      (busy4)
  );

  btn_debounce #(.STABLE_CYCLES(1), .CNT_WIDTH(1)) dut1 (
    .clk       (clock),
    .rst       (reset),
    .btn_in    (btnIn),
    .btn_level (level1),
    .btn_rise  (rise1),
    .btn_fall  (fall1),
    .busy      (busy1)
  );

  always #5 clock = ~clock;

  // Drive inputs just after an edge so the next rising edge samples them, then
  // step past that edge so outputs are read away from it.
  task automatic applyStimulus(input logic btnVal, input logic rstVal);
    btnIn = btnVal;
    reset = rstVal;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic eLevel, input logic eRise,
                          input logic eFall, input logic eBusy);
    checkOutput({tag, " level"}, level4, eLevel);
    checkOutput({tag, " rise"},  rise4,  eRise);
    checkOutput({tag, " fall"},  fall4,  eFall);
    checkOutput({tag, " busy"},  busy4,  eBusy);
  endtask

  initial begin
    btnIn = 1'b1;
    reset = 1'b1;

    $display("[TB] reset with btn_in high");
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(1'b1, 1'b1);
      checkAll($sformatf("reset c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkAll("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] clean press");
    for (int e = 1; e <= 20; e++) begin
      applyStimulus(1'b1, 1'b0);
      checkAll($sformatf("press e%0d", e), e >= 7, e == 7, 1'b0, (e >= 3) && (e <= 6));
      checkOutput($sformatf("sc1 press e%0d level", e), level1, e >= 4);
      checkOutput($sformatf("sc1 press e%0d rise", e), rise1, e == 4);
      checkOutput($sformatf("sc1 press e%0d busy", e), busy1, e == 3);
    end

    $display("[TB] clean release");
    for (int e = 1; e <= 12; e++) begin
      applyStimulus(1'b0, 1'b0);
      checkAll($sformatf("release e%0d", e), e < 7, 1'b0, e == 7, (e >= 3) && (e <= 6));
    end

    $display("[TB] bounce rejection");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(bouncePattern[i], 1'b0);
      checkAll($sformatf("bounce e%0d", i + 1), 1'b0, 1'b0, 1'b0, bounceBusy[i]);
    end
    for (int e = 1; e <= 6; e++) begin
      applyStimulus(1'b0, 1'b0);
      checkAll($sformatf("bounce tail e%0d", e), 1'b0, 1'b0, 1'b0, e == 1);
    end

    $display("[TB] reset during qualification");
    for (int e = 1; e <= 13; e++) begin
      applyStimulus(1'b1, e == 4);
      if (e <= 3)
        checkAll($sformatf("midrst e%0d", e), 1'b0, 1'b0, 1'b0, e == 3);
      else if (e == 4)
        checkAll("midrst reset edge", 1'b0, 1'b0, 1'b0, 1'b0);
      else
        checkAll($sformatf("midrst e%0d", e), e >= 11, e == 11, 1'b0, (e >= 7) && (e <= 10));
    end

    $display("[TB] short glitch while high");
    for (int e = 1; e <= 10; e++) begin
      applyStimulus((e <= 2) ? 1'b0 : 1'b1, 1'b0);
      checkAll($sformatf("glitch e%0d", e), 1'b1, 1'b0, 1'b0, (e == 3) || (e == 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
